// File: rtl/shift_reg_n.sv
// ---------------------------------------------------------------------------
// shift_reg_n
//
// Purpose:
//   W-bit wide, N-stage delay line with a clock enable. It is the building
//   block for fixed-latency pipelines, for example when valid, function,
//   state and product fields all have to be delayed by the same number of
//   cycles as a multiplier. Each enabled rising edge moves every stage one
//   step forward, and q is the oldest stage. When N is 0 the block is just a
//   wire from d to q.
//
// Parameters:
//   W      : data width in bits. Must be at least 1.
//   N      : number of register stages, which is the latency in enabled
//            edges. Must be at least 0.
//
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous, active-high reset. Clears every stage to zero.
//   clk_en : stages advance only on edges where this is 1
//   d      : data in (W bits)
//   q      : data out (W bits); d delayed by N enabled edges
//
// Notes:
//   - The block treats data as opaque bits and passes all W bits unchanged.
//   - Reset takes priority over clk_en.
//   - There is no combinational path from d to q when N >= 1, so synthesis
//     is free to retime the stages, for example into DSP pipeline registers.
// ---------------------------------------------------------------------------
module shift_reg_n #(
  parameter int W = 1,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Reject illegal parameter values when the design elaborates.
  if (W < 1 || N < 0) begin : g_bad_param
    $error("shift_reg_n: illegal parameters W=%0d N=%0d (need W>=1, N>=0)", W, N);
  end

  if (N == 0) begin : g_wire
    // Zero latency. No flops are built, so clk, rst and clk_en have nothing
    // to drive. They are tied off here so they do not show up as dangling.
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst, clk_en};
    assign q = d;
  end else if (N >= 1) begin : g_regs
    // r_stage[0] holds the newest sample and r_stage[N-1] the oldest.
    logic [W-1:0] r_stage [N];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < N; i++) begin
          r_stage[i] <= '0;
        end
      end else if (clk_en) begin
        r_stage[0] <= d;
        for (int i = 1; i < N; i++) begin
          r_stage[i] <= r_stage[i-1];
        end
      end
    end

    assign q = r_stage[N-1];
  end else begin : g_none
    // Only reachable with illegal parameters, which are already reported
    // above. q is tied to zero so the output is still driven.
    assign q = '0;
  end

endmodule

// File: tb/tb_shift_reg_n.sv
// ---------------------------------------------------------------------------
// tb_shift_reg_n
//
// Builds four instances of shift_reg_n that share one clock:
//   u3 : N=3, W=8
//   u2 : N=2, W=32
//   u0 : N=0, W=16
//   u1 : N=1, W=1
//
// Each registered instance has a model in this bench. The model is a queue
// that holds exactly N words. On an enabled edge the new word goes in at the
// back and the oldest word leaves at the front. Reset refills the queue with
// zeros. The expected q is always the front of the queue.
//
// Inputs change 2 time units after a rising edge, and the compare process
// samples on the falling edge. The directed sequences also check
// hand-computed literal values, including checks inside the cycle right
// after an asynchronous reset is asserted.
// ---------------------------------------------------------------------------
module tb_shift_reg_n;

  // ---------------- clock ----------------
  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT signals ----------------
  logic        rst3, en3;
  logic [7:0]  d3, q3;
  logic        rst2, en2;
  logic [31:0] d2, q2;
  logic        rst0, en0;
  logic [15:0] d0, q0;
  logic        rst1, en1;
  logic [0:0]  d1, q1;

  shift_reg_n #(.W(8),  .N(3)) u3 (.clk(clk), .rst(rst3), .clk_en(en3), .d(d3), .q(q3));
  shift_reg_n #(.W(32), .N(2)) u2 (.clk(clk), .rst(rst2), .clk_en(en2), .d(d2), .q(q2));
  shift_reg_n #(.W(16), .N(0)) u0 (.clk(clk), .rst(rst0), .clk_en(en0), .d(d0), .q(q0));
  shift_reg_n #(.W(1),  .N(1)) u1 (.clk(clk), .rst(rst1), .clk_en(en1), .d(d1), .q(q1));

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: fixed-length queues ----------------
  logic [31:0] m3[$];
  logic [31:0] m2[$];
  logic [31:0] m1[$];

  always @(posedge clk or posedge rst3) begin
    if (rst3) m3 = '{32'd0, 32'd0, 32'd0};
    else if (en3) begin
      m3.push_back({24'd0, d3});
      m3.delete(0);
    end
  end

  always @(posedge clk or posedge rst2) begin
    if (rst2) m2 = '{32'd0, 32'd0};
    else if (en2) begin
      m2.push_back(d2);
      m2.delete(0);
    end
  end

  always @(posedge clk or posedge rst1) begin
    if (rst1) m1 = '{32'd0};
    else if (en1) begin
      m1.push_back({31'd0, d1});
      m1.delete(0);
    end
  end

  // Compare every instance against its model on each falling edge.
  always @(negedge clk) begin
    if (m3.size() == 3) check("model_q3", {24'd0, q3}, m3[0]);
    if (m2.size() == 2) check("model_q2", q2, m2[0]);
    if (m1.size() == 1) check("model_q1", {31'd0, q1}, m1[0]);
    check("model_q0", {16'd0, q0}, {16'd0, d0});
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [7:0] t1_d   [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00};
  logic [7:0] t1_exp [6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    rst3 = 1'b1; en3 = 1'b1; d3 = '0;
    rst2 = 1'b1; en2 = 1'b1; d2 = '0;
    rst0 = 1'b1; en0 = 1'b0; d0 = '0;
    rst1 = 1'b1; en1 = 1'b1; d1 = '0;
    repeat (2) tick();

    // Reset state of every registered instance.
    check("reset_q3", {24'd0, q3}, 32'd0);
    check("reset_q2", q2, 32'd0);
    check("reset_q1", {31'd0, q1}, 32'd0);
    rst3 = 1'b0; rst2 = 1'b0; rst1 = 1'b0;
    tick();

    // N=3: stream 0x11..0x44 on consecutive enabled edges.
    d3 = t1_d[0];
    check("t1_pre", {24'd0, q3}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("t1_q%0d", i), {24'd0, q3}, {24'd0, t1_exp[i]});
      if (i < 5) d3 = t1_d[i+1];
    end

    // N=3: load 0xA5, stall for 4 cycles while d=0xFF, then resume.
    d3 = 8'hA5;
    tick();
    check("t2_load", {24'd0, q3}, 32'd0);
    en3 = 1'b0; d3 = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t2_stall%0d", i), {24'd0, q3}, 32'd0);
    end
    en3 = 1'b1;
    tick();
    check("t2_e2", {24'd0, q3}, 32'd0);
    tick();
    check("t2_e3", {24'd0, q3}, 32'h0000_00A5);
    tick();
    check("t2_e4", {24'd0, q3}, 32'h0000_00FF);

    // N=2: fill the stages, then assert reset in the middle of a cycle.
    d2 = 32'hDEAD_BEEF;
    tick();
    d2 = 32'h1234_5678;
    tick();
    check("t3_full", q2, 32'hDEAD_BEEF);
    #1 rst2 = 1'b1;
    #1 check("t3_async", q2, 32'd0);
    d2 = 32'h5;
    tick();
    check("t3_held", q2, 32'd0);
    rst2 = 1'b0;
    #1 check("t3_rel", q2, 32'd0);
    tick();
    check("t3_e1", q2, 32'd0);
    tick();
    check("t3_e2", q2, 32'h5);

    // N=0: q follows d within the cycle, whatever rst and clk_en are.
    rst0 = 1'b1; en0 = 1'b0; d0 = 16'h0000;
    #1 check("t4_zero", {16'd0, q0}, 32'd0);
    #1 d0 = 16'hBEEF;
    #1 check("t4_beef", {16'd0, q0}, 32'h0000_BEEF);

    // N=1, W=1: alternate d, then hold reset with clk_en=1.
    d1 = 1'b1;
    tick();
    check("t5_a1", {31'd0, q1}, 32'd1);
    d1 = 1'b0;
    tick();
    check("t5_a0", {31'd0, q1}, 32'd0);
    d1 = 1'b1;
    tick();
    check("t5_b1", {31'd0, q1}, 32'd1);
    rst1 = 1'b1;
    #1 check("t5_rst", {31'd0, q1}, 32'd0);
    tick();
    check("t5_rst_e1", {31'd0, q1}, 32'd0);
    tick();
    check("t5_rst_e2", {31'd0, q1}, 32'd0);
    rst1 = 1'b0;
    #1 check("t5_rel", {31'd0, q1}, 32'd0);
    tick();
    check("t5_first", {31'd0, q1}, 32'd1);

    // Random-valued traffic with a random enable, checked by the model only.
    for (int i = 0; i < 40; i++) begin
      en3 = 1'($urandom_range(0, 1));
      en2 = 1'($urandom_range(0, 1));
      en1 = 1'($urandom_range(0, 1));
      d3  = 8'($urandom_range(0, 255));
      d2  = $urandom;
      d1  = 1'($urandom_range(0, 1));
      d0  = 16'($urandom_range(0, 65535));
      tick();
    end

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
